// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant encodings and starvation counter sizing for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;
  localparam int STARVE_MAX_DEF = 4;
  function automatic int starve_w(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction
  localparam int STARVE_W = starve_w(STARVE_MAX_DEF);
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: level-held line request bus between a cache (master) and memory (slave)
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport master(output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave(input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-priority winner selection, yielding to I once D has starved it STARVE_MAX times
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  localparam int CW = starve_w(STARVE_MAX)
) (
  input  logic          i_req_i,
  input  logic          i_req_d,
  input  logic [CW-1:0] i_starve_cnt,
  output logic          o_pick_i,
  output logic          o_pick_d
);
  logic w_force_i;
  assign w_force_i = i_req_i && (i_starve_cnt == CW'(STARVE_MAX));
  assign o_pick_d  = i_req_d && !w_force_i;
  assign o_pick_i  = i_req_i && !o_pick_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow memory between the I-cache and D-cache ports,
// one transaction at a time, with an IDLE turnaround cycle after each completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave  icache,
  mem_arbiter_if.slave  dcache,
  mem_arbiter_if.master mem,
  output logic [1:0]   grant
);
  localparam int CW = starve_w(STARVE_MAX);
  state_t            r_state, w_next;
  logic              r_rd, r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_starve_cnt;
  logic              w_req_i, w_req_d, w_pick_i, w_pick_d, w_busy;
  assign w_req_i = icache.mem_read | icache.mem_write;
  assign w_req_d = dcache.mem_read | dcache.mem_write;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_req_i     (w_req_i),
    .i_req_d     (w_req_d),
    .i_starve_cnt(r_starve_cnt),
    .o_pick_i    (w_pick_i),
    .o_pick_d    (w_pick_d)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_pick_d ? SERVE_D : w_pick_i ? SERVE_I : IDLE;
    else if (mem.mem_ready) w_next = IDLE;
  end
  // Commands are latched only on the grant edge, so a requester that withdraws mid-serve cannot disturb memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_pick_d) begin
        r_rd         <= dcache.mem_read;
        r_wr         <= dcache.mem_write;
        r_addr       <= dcache.mem_addr;
        r_wdata      <= dcache.mem_wdata;
        r_starve_cnt <= !w_req_i ? '0 : (r_starve_cnt == CW'(STARVE_MAX)) ? r_starve_cnt : r_starve_cnt + CW'(1);
      end else if (r_state == IDLE && w_pick_i) begin
        r_rd         <= icache.mem_read;
        r_wr         <= icache.mem_write;
        r_addr       <= icache.mem_addr;
        r_wdata      <= icache.mem_wdata;
        r_starve_cnt <= '0;
      end
    end
  end
  assign w_busy           = r_state != IDLE;
  assign mem.mem_read     = w_busy & r_rd;
  assign mem.mem_write    = w_busy & r_wr;
  assign mem.mem_addr     = w_busy ? r_addr : '0;
  assign mem.mem_wdata    = w_busy ? r_wdata : '0;
  assign icache.mem_ready = (r_state == SERVE_I) & mem.mem_ready;
  assign dcache.mem_ready = (r_state == SERVE_D) & mem.mem_ready;
  assign icache.mem_rdata = mem.mem_rdata;
  assign dcache.mem_rdata = mem.mem_rdata;
  assign grant = (r_state == SERVE_I) ? GNT_I : (r_state == SERVE_D) ? GNT_D : GNT_NONE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios against a 3-cycle-latency memory model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] grant;
  int tests = 0;
  int fails = 0;
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) ic ();
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) dc ();
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) mm ();
  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .icache(ic), .dcache(dc), .mem(mm), .grant(grant)
  );
  always #5 clk = ~clk;
  logic [1:0] r_lat;
  logic r_mrdy, hold, spur;
  always @(posedge clk) begin
    if (!rst_n || hold || !(mm.mem_read | mm.mem_write) || r_mrdy) begin
      r_lat <= 2'd0;
      r_mrdy <= 1'b0;
    end else if (r_lat == 2'd2) begin
      r_lat <= 2'd0;
      r_mrdy <= 1'b1;
    end else r_lat <= r_lat + 2'd1;
  end
  assign mm.mem_ready = r_mrdy | spur;
  assign mm.mem_rdata = {100'h0, mm.mem_addr} ^ {4{32'h5A5A_C3C3}};
  function automatic logic [127:0] exp_rd(input logic [27:0] a);
    return {100'h0, a} ^ {4{32'h5A5A_C3C3}};
  endfunction
  logic [1:0] g_q[$];
  int c_q[$];
  logic [1:0] prev_g = 2'b00;
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (grant != 2'b00 && prev_g == 2'b00) begin
      g_q.push_back(grant);
      c_q.push_back(int'(dut.r_starve_cnt));
    end
    prev_g = grant;
    if (mm.mem_ready && mm.mem_write) wr_cnt++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = is_d ? dc.mem_ready : ic.mem_ready;
    end
  endtask
  task automatic test_reset();
    ic.mem_read = 0; ic.mem_write = 0; ic.mem_addr = '0; ic.mem_wdata = '0;
    dc.mem_read = 0; dc.mem_write = 0; dc.mem_addr = '0; dc.mem_wdata = '0;
    hold = 0; spur = 0; rst_n = 0;
    step(); step();
    tests++;
    if (grant !== 2'b00 || mm.mem_read !== 1'b0 || mm.mem_write !== 1'b0 || mm.mem_addr !== 28'h0) begin
      fails++; $display("FAIL reset_outputs: grant=%b rd=%b wr=%b addr=%h, expected all 0", grant, mm.mem_read, mm.mem_write, mm.mem_addr);
    end
    tests++;
    if (dut.r_state !== IDLE || dut.r_starve_cnt !== 3'd0) begin
      fails++; $display("FAIL reset_state: state=%0d cnt=%0d, expected IDLE/0", dut.r_state, dut.r_starve_cnt);
    end
    rst_n = 1;
    step();
  endtask
  task automatic test_single_i();
    int n_i = 0;
    int bad_d = 0;
    bit chk = 0;
    ic.mem_read = 1; ic.mem_addr = 28'h0000010;
    step();
    tests++;
    if (mm.mem_read !== 1'b1 || mm.mem_addr !== 28'h0000010 || grant !== GNT_I) begin
      fails++; $display("FAIL single_i_issue: rd=%b addr=%h grant=%b, expected 1/0000010/01", mm.mem_read, mm.mem_addr, grant);
    end
    for (int k = 0; k < 8; k++) begin
      if (chk) begin
        tests++;
        if (mm.mem_read !== 1'b0 || grant !== GNT_NONE) begin
          fails++; $display("FAIL single_i_turnaround: rd=%b grant=%b, expected 0/00", mm.mem_read, grant);
        end
        chk = 0;
      end
      if (dc.mem_ready) bad_d++;
      if (ic.mem_ready) begin
        n_i++;
        tests++;
        if (ic.mem_rdata !== exp_rd(28'h0000010)) begin
          fails++; $display("FAIL single_i_rdata: got %h expected %h", ic.mem_rdata, exp_rd(28'h0000010));
        end
        ic.mem_read = 0;
        chk = 1;
      end
      step();
    end
    tests++;
    if (n_i != 1 || bad_d != 0) begin
      fails++; $display("FAIL single_i_ready_count: i_ready=%0d d_ready=%0d, expected 1/0", n_i, bad_d);
    end
  endtask
  task automatic test_d_priority();
    bit ok;
    ic.mem_read = 1; ic.mem_addr = 28'h0000020;
    dc.mem_write = 1; dc.mem_addr = 28'h0000030; dc.mem_wdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222;
    step();
    tests++;
    if (grant !== GNT_D || mm.mem_write !== 1'b1 || mm.mem_read !== 1'b0 || mm.mem_addr !== 28'h0000030 ||
        mm.mem_wdata !== 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1111_2222) begin
      fails++; $display("FAIL dprio_d_first: grant=%b wr=%b rd=%b addr=%h wdata=%h, expected 10/1/0/0000030/deadbeef..", grant, mm.mem_write, mm.mem_read, mm.mem_addr, mm.mem_wdata);
    end
    wait_rdy(1, ok);
    tests++;
    if (!ok || ic.mem_ready !== 1'b0) begin
      fails++; $display("FAIL dprio_d_ready: d_ready_seen=%b i_ready=%b, expected 1/0", ok, ic.mem_ready);
    end
    dc.mem_write = 0;
    step();
    tests++;
    if (grant !== GNT_NONE || mm.mem_read !== 1'b0 || mm.mem_write !== 1'b0) begin
      fails++; $display("FAIL dprio_idle: grant=%b rd=%b wr=%b, expected 00/0/0", grant, mm.mem_read, mm.mem_write);
    end
    step();
    tests++;
    if (grant !== GNT_I || mm.mem_read !== 1'b1 || mm.mem_addr !== 28'h0000020) begin
      fails++; $display("FAIL dprio_i_second: grant=%b rd=%b addr=%h, expected 01/1/0000020", grant, mm.mem_read, mm.mem_addr);
    end
    wait_rdy(0, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL dprio_i_ready: i_ready_seen=%b, expected 1", ok);
    end
    ic.mem_read = 0;
    step();
  endtask
  task automatic test_back_to_back();
    bit ok;
    int wr0 = wr_cnt;
    dc.mem_write = 1; dc.mem_addr = 28'h00000A0; dc.mem_wdata = 128'h0F0F;
    step();
    tests++;
    if (mm.mem_write !== 1'b1 || mm.mem_addr !== 28'h00000A0) begin
      fails++; $display("FAIL b2b_wb_issue: wr=%b addr=%h, expected 1/00000a0", mm.mem_write, mm.mem_addr);
    end
    wait_rdy(1, ok);
    dc.mem_write = 0; dc.mem_read = 1; dc.mem_addr = 28'h00000B0;
    step();
    tests++;
    if (!ok || mm.mem_write !== 1'b0 || mm.mem_read !== 1'b0 || grant !== GNT_NONE) begin
      fails++; $display("FAIL b2b_idle: ready_seen=%b wr=%b rd=%b grant=%b, expected 1/0/0/00", ok, mm.mem_write, mm.mem_read, grant);
    end
    step();
    tests++;
    if (mm.mem_read !== 1'b1 || mm.mem_write !== 1'b0 || mm.mem_addr !== 28'h00000B0) begin
      fails++; $display("FAIL b2b_alloc_issue: rd=%b wr=%b addr=%h, expected 1/0/00000b0", mm.mem_read, mm.mem_write, mm.mem_addr);
    end
    wait_rdy(1, ok);
    dc.mem_read = 0;
    step();
    tests++;
    if (!ok || wr_cnt - wr0 != 1) begin
      fails++; $display("FAIL b2b_write_count: ready_seen=%b writes=%0d, expected 1/1", ok, wr_cnt - wr0);
    end
  endtask
  task automatic test_starvation();
    logic [1:0] exp_g[6] = '{GNT_D, GNT_D, GNT_D, GNT_D, GNT_I, GNT_D};
    int exp_c[6] = '{1, 2, 3, 4, 0, 1};
    int n0 = g_q.size();
    ic.mem_read = 1; ic.mem_addr = 28'h0000040;
    dc.mem_read = 1; dc.mem_addr = 28'h0000050;
    for (int k = 0; k < 200 && g_q.size() - n0 < 6; k++) step();
    ic.mem_read = 0; dc.mem_read = 0;
    tests++;
    if (g_q.size() - n0 < 6) begin
      fails++; $display("FAIL starve_timeout: grants=%0d, expected 6", g_q.size() - n0);
    end else begin
      for (int j = 0; j < 6; j++) begin
        tests++;
        if (g_q[n0 + j] !== exp_g[j] || c_q[n0 + j] != exp_c[j]) begin
          fails++; $display("FAIL starve_grant%0d: grant=%b cnt=%0d, expected %b/%0d", j, g_q[n0 + j], c_q[n0 + j], exp_g[j], exp_c[j]);
        end
      end
    end
    for (int k = 0; k < 20 && grant != GNT_NONE; k++) step();
    step();
    tests++;
    if (grant !== GNT_NONE) begin
      fails++; $display("FAIL starve_drain: grant=%b, expected 00", grant);
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    hold = 1;
    dc.mem_write = 1; dc.mem_addr = 28'h0000060; dc.mem_wdata = 128'h77;
    step();
    tests++;
    if (grant !== GNT_D) begin
      fails++; $display("FAIL rstmid_grant: grant=%b, expected 10", grant);
    end
    step();
    rst_n = 0;
    step();
    tests++;
    if (grant !== GNT_NONE || mm.mem_write !== 1'b0 || mm.mem_read !== 1'b0 || mm.mem_addr !== 28'h0 ||
        mm.mem_wdata !== 128'h0 || dc.mem_ready !== 1'b0 || dut.r_state !== IDLE) begin
      fails++; $display("FAIL rstmid_clear: grant=%b wr=%b rd=%b addr=%h ready=%b state=%0d, expected all 0/IDLE", grant, mm.mem_write, mm.mem_read, mm.mem_addr, dc.mem_ready, dut.r_state);
    end
    rst_n = 1;
    step();
    tests++;
    if (grant !== GNT_D || mm.mem_write !== 1'b1 || mm.mem_addr !== 28'h0000060) begin
      fails++; $display("FAIL rstmid_regrant: grant=%b wr=%b addr=%h, expected 10/1/0000060", grant, mm.mem_write, mm.mem_addr);
    end
    hold = 0;
    wait_rdy(1, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rstmid_ready: d_ready_seen=%b, expected 1", ok);
    end
    dc.mem_write = 0;
    step();
  endtask
  task automatic test_spurious();
    spur = 1;
    #1;
    tests++;
    if (ic.mem_ready !== 1'b0 || dc.mem_ready !== 1'b0) begin
      fails++; $display("FAIL spurious_ready: i_ready=%b d_ready=%b, expected 0/0", ic.mem_ready, dc.mem_ready);
    end
    step();
    spur = 0;
    tests++;
    if (dut.r_state !== IDLE || grant !== GNT_NONE) begin
      fails++; $display("FAIL spurious_state: state=%0d grant=%b, expected IDLE/00", dut.r_state, grant);
    end
  endtask
  initial begin
    test_reset();
    test_single_i();
    test_d_priority();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one slow main memory between the I-cache and D-cache miss/write-back ports; replaces the two private slow memories.
- Sits between the two cache instances and the memory. Each cache keeps its existing level-held mem_read/mem_write/mem_addr/mem_wdata interface and its one-cycle mem_ready handshake.
- Fixed D-priority arbitration with a starvation cap for the I port; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 28, block address width (byte address bits 31:4)
- DATA_W, 128, cache line width
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_mem_read  in  1  I-cache line read request (level, held until i_mem_ready)
- i_mem_write  in  1  I-cache line write request (tie 0 in CHIP; still arbitrated)
- i_mem_addr  in  ADDR_W  I-cache block address
- i_mem_wdata  in  DATA_W  I-cache write line
- i_mem_rdata  out  DATA_W  read line to I-cache
- i_mem_ready  out  1  completion pulse to I-cache
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready  same as the i_ group, D-cache side
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_rdata  in  DATA_W  from memory
- mem_ready  in  1  one-cycle completion pulse from memory
- grant  out  2  debug: 2'b01 I served, 2'b10 D served, 2'b00 idle

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Encoding lives in the package.
- Reset: state=IDLE, starve_cnt=0, command registers=0, every output 0. A reset during SERVE_x abandons the transaction; the memory is reset by the same rst_n.
- Pending conditions: req_i = i_mem_read|i_mem_write; req_d = d_mem_read|d_mem_write.
- Arbitration happens only in IDLE:
  - req_d & !(req_i & starve_cnt==STARVE_MAX) -> SERVE_D.
  - else req_i -> SERVE_I.
  - else stay in IDLE.
- Grant cycle:
  - Latch read, write, addr and wdata of the winner into command registers on the same edge as the state change.
  - mem_* outputs are driven only from the command registers, and only in SERVE_x. They are 0 in IDLE.
- Latency:
  - A request visible in IDLE at cycle t makes mem_read/mem_write high at t+1.
  - Each transaction ends with at least one IDLE cycle, the turnaround during which mem_read=mem_write=0.
- Completion:
  - In SERVE_x with mem_ready=1, x_mem_ready=1 for exactly that cycle and the next state is IDLE.
  - x_mem_ready is never asserted outside SERVE_x. The non-granted port's ready stays 0 even while mem_ready=1.
- Read data: i_mem_rdata = d_mem_rdata = mem_rdata, broadcast. Qualification is by the ready strobes only.
- Stale request: the cache drops or changes its request the cycle after ready. Because arbitration restarts in IDLE at t+1, fresh values are sampled and there is no double grant.
- Simultaneous read and write from one port: both bits are forwarded as latched. This is not generated by the caches and there is no ordering guarantee.
- Starvation counter:
  - On an IDLE->SERVE_D grant with req_i=1, starve_cnt increments, saturating at STARVE_MAX.
  - On any SERVE_I grant, starve_cnt clears.
  - A D grant with req_i=0 also clears starve_cnt.
- Request withdrawal: if the granted requester drops its request mid-SERVE (protocol violation), the arbiter still holds the command until mem_ready.
- Width: starve_cnt is $clog2(STARVE_MAX+1) bits and must not wrap.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE/SERVE_I/SERVE_D)
  - grant encodings (GNT_NONE/GNT_I/GNT_D)
  - localparam for the starve counter width
- One natural sub-module: mem_arb_pick, the combinational winner selection from req_i, req_d and starve_cnt. The rest (FSM, command registers, counter, ready routing) stays in mem_arbiter.

Test Plan:
- Single I read at addr 0x0000010 with a 3-cycle memory latency:
  - mem_read=1 and mem_addr=0x0000010 one cycle after the request.
  - i_mem_ready pulses once with mem_rdata.
  - d_mem_ready stays 0 throughout.
  - Next cycle mem_read=0.
- I read and D write asserted in the same cycle: D is served first (mem_write=1, d addr/wdata). After d_mem_ready there is one IDLE cycle, then I is served.
- D issues a write-back to 0x00000A0 followed immediately by an allocate read to 0x00000B0: two separate transactions separated by an IDLE cycle, with no duplicate write.
- I held pending and D re-requests continuously with STARVE_MAX=4:
  - Grant order is D,D,D,D,I,D.
  - starve_cnt reaches 4 and then clears.
- rst_n=0 asserted during SERVE_D before mem_ready: the next cycle has all outputs 0, state IDLE and grant=0. After release, the pending D request is re-granted.
- mem_ready asserted spuriously while in IDLE: neither x_mem_ready is asserted and the state is unchanged.
